// File: rtl/flags_unit.sv
// -----------------------------------------------------------------------------
// flags_unit
//
// Producer of the architectural condition flags {Z, C, N, V}. The flags are
// updated from ALU results, written directly by the CPU, or saved/restored
// through a small LIFO used on exception/interrupt entry and exit.
//
// Output bit order matches the branch-condition checker:
//   flags[3]=Z, flags[2]=C, flags[1]=N, flags[0]=V
//
// Ports:
//   clk            system clock, all state changes on the rising edge
//   rst_n          asynchronous active-low reset
//   alu_result     ALU result of the current instruction
//   alu_carry      adder carry-out
//   alu_overflow   adder signed overflow
//   shifter_carry  barrel-shifter carry-out (used for logical ops)
//   op_logic       logical op: C from shifter_carry, V preserved
//   set_flags      update flags from the ALU this cycle
//   flags_wr       direct write of flags_wdata
//   flags_wdata    {Z,C,N,V} for a direct write
//   push           save current flags onto the stack
//   pop            restore flags from the top of the stack
//   err_clr        clear stack_err
//   flags          registered flags {Z,C,N,V}
//   flags_updated  one-cycle pulse: flags changed value on the previous edge
//   stack_count    number of occupied stack entries
//   stack_full     stack_count == DEPTH
//   stack_empty    stack_count == 0
//   stack_err      sticky overflow/underflow/push-pop conflict error
//
// Control strobes: push, pop, set_flags, flags_wr and err_clr are single-cycle
// request strobes with no handshake; each one is acted on (or rejected and
// reported through stack_err) on the rising edge where it is sampled high.
// -----------------------------------------------------------------------------
module flags_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    input  logic             shifter_carry,
    input  logic             op_logic,
    input  logic             set_flags,
    input  logic             flags_wr,
    input  logic [3:0]       flags_wdata,
    input  logic             push,
    input  logic             pop,
    input  logic             err_clr,
    output logic [3:0]       flags,
    output logic             flags_updated,
    output logic [CW-1:0]    stack_count,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             stack_err
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [3:0]    flags_q,   flags_d;
    logic          updated_q, updated_d;
    logic [CW-1:0] count_q,   count_d;
    logic          err_q,     err_d;
    logic [3:0]    stack_q [DEPTH];
    logic [3:0]    stack_d [DEPTH];

    // -------------------------------------------------------------------------
    // Stack status and request qualification
    // -------------------------------------------------------------------------
    logic       full;
    logic       empty;
    logic       push_ok;
    logic       pop_ok;
    logic       err_evt;
    logic [3:0] top_entry;
    logic [3:0] alu_flags;
    logic       alu_z;
    logic       alu_c;
    logic       alu_n;
    logic       alu_v;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // A simultaneous push and pop is treated as a conflict: neither is
    // performed, so the stack contents and count stay untouched.
    assign push_ok = push & ~pop & ~full;
    assign pop_ok  = pop & ~push & ~empty;
    assign err_evt = (push & pop) | (push & full) | (pop & empty);

    // Top-of-stack read, selected by comparing against the count so that the
    // index never needs a width-adjusting subtraction.
    always_comb begin
        top_entry = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (count_q == CW'(i + 1)) begin
                top_entry = stack_q[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // ALU flag computation. For logical ops the adder outputs are meaningless,
    // so C comes from the shifter and V keeps its current value.
    // -------------------------------------------------------------------------
    assign alu_z     = (alu_result == '0);
    assign alu_n     = alu_result[WIDTH-1];
    assign alu_c     = op_logic ? shifter_carry : alu_carry;
    assign alu_v     = op_logic ? flags_q[0]    : alu_overflow;
    assign alu_flags = {alu_z, alu_c, alu_n, alu_v};

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // Flag source priority: valid pop > direct write > ALU update.
        // A rejected pop falls through to the lower-priority sources.
        flags_d = flags_q;
        if (pop_ok) begin
            flags_d = top_entry;
        end else if (flags_wr) begin
            flags_d = flags_wdata;
        end else if (set_flags) begin
            flags_d = alu_flags;
        end

        updated_d = (flags_d != flags_q);

        count_d = count_q;
        if (push_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok) begin
            count_d = count_q - CW'(1);
        end

        // Push saves the value held before this edge, even if a write or ALU
        // update loads a new value on the same edge.
        for (int i = 0; i < DEPTH; i++) begin
            stack_d[i] = stack_q[i];
            if (push_ok && (count_q == CW'(i))) begin
                stack_d[i] = flags_q;
            end
        end

        // An error on the same edge as err_clr wins, so no event is lost.
        err_d = err_q;
        if (err_evt) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q   <= '0;
            updated_q <= 1'b0;
            count_q   <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            flags_q   <= flags_d;
            updated_q <= updated_d;
            count_q   <= count_d;
            err_q     <= err_d;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= stack_d[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign flags         = flags_q;
    assign flags_updated = updated_q;
    assign stack_count   = count_q;
    assign stack_full    = full;
    assign stack_empty   = empty;
    assign stack_err     = err_q;

endmodule

// File: tb/tb_flags_unit.sv
// -----------------------------------------------------------------------------
// tb_flags_unit
//
// Directed testbench for flags_unit with hand-computed expected values.
// Inputs are driven 1 time unit after a rising edge and outputs are sampled
// 1 time unit after the following rising edge.
// -----------------------------------------------------------------------------
module tb_flags_unit;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             alu_overflow;
    logic             shifter_carry;
    logic             op_logic;
    logic             set_flags;
    logic             flags_wr;
    logic [3:0]       flags_wdata;
    logic             push;
    logic             pop;
    logic             err_clr;
    logic [3:0]       flags;
    logic             flags_updated;
    logic [CW-1:0]    stack_count;
    logic             stack_full;
    logic             stack_empty;
    logic             stack_err;

    int checks;
    int failures;

    flags_unit #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_result    (alu_result),
        .alu_carry     (alu_carry),
        .alu_overflow  (alu_overflow),
        .shifter_carry (shifter_carry),
        .op_logic      (op_logic),
        .set_flags     (set_flags),
        .flags_wr      (flags_wr),
        .flags_wdata   (flags_wdata),
        .push          (push),
        .pop           (pop),
        .err_clr       (err_clr),
        .flags         (flags),
        .flags_updated (flags_updated),
        .stack_count   (stack_count),
        .stack_full    (stack_full),
        .stack_empty   (stack_empty),
        .stack_err     (stack_err)
    );

    // ---------------------------------------------------------------- clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set_flags   = 1'b0;
        flags_wr    = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        err_clr     = 1'b0;
        flags_wdata = 4'b0000;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst_n         = 1'b0;
        alu_result    = '0;
        alu_carry     = 1'b0;
        alu_overflow  = 1'b0;
        shifter_carry = 1'b0;
        op_logic      = 1'b0;
        idle();
        tick();
        tick();
        checks++;
        if (flags !== 4'b0000 || flags_updated !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: got flags=%b upd=%b expected 0000/0", flags, flags_updated);
        end
        checks++;
        if (stack_count !== CW'(0) || stack_empty !== 1'b1 || stack_full !== 1'b0 || stack_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_stack: got count=%0d empty=%b full=%b err=%b expected 0/1/0/0",
                     stack_count, stack_empty, stack_full, stack_err);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (flags !== 4'b0000 || stack_count !== CW'(0)) begin
            failures++;
            $display("FAIL reset_release: got flags=%b count=%0d expected 0000/0", flags, stack_count);
        end
    endtask

    task automatic test_alu_flags();
        // Zero result with carry: Z=1 C=1 N=0 V=0
        alu_result   = 32'h0000_0000;
        alu_carry    = 1'b1;
        alu_overflow = 1'b0;
        op_logic     = 1'b0;
        set_flags    = 1'b1;
        tick();
        idle();
        checks++;
        if (flags !== 4'b1100 || flags_updated !== 1'b1) begin
            failures++;
            $display("FAIL alu_zero: got flags=%b upd=%b expected 1100/1", flags, flags_updated);
        end
        tick();
        checks++;
        if (flags !== 4'b1100 || flags_updated !== 1'b0) begin
            failures++;
            $display("FAIL alu_hold: got flags=%b upd=%b expected 1100/0", flags, flags_updated);
        end
        // Negative result with overflow: Z=0 C=0 N=1 V=1
        alu_result   = 32'h8000_0000;
        alu_carry    = 1'b0;
        alu_overflow = 1'b1;
        set_flags    = 1'b1;
        tick();
        idle();
        checks++;
        if (flags !== 4'b0011) begin
            failures++;
            $display("FAIL alu_negative: got %b expected 0011", flags);
        end
        // Logical op: C from shifter, V preserved even though alu_overflow=0
        alu_result    = 32'd5;
        alu_overflow  = 1'b0;
        alu_carry     = 1'b0;
        shifter_carry = 1'b1;
        op_logic      = 1'b1;
        set_flags     = 1'b1;
        tick();
        idle();
        checks++;
        if (flags !== 4'b0101 || flags_updated !== 1'b1) begin
            failures++;
            $display("FAIL alu_logic: got flags=%b upd=%b expected 0101/1", flags, flags_updated);
        end
        // Same inputs again: value unchanged so no update pulse
        set_flags = 1'b1;
        tick();
        idle();
        checks++;
        if (flags !== 4'b0101 || flags_updated !== 1'b0) begin
            failures++;
            $display("FAIL alu_same_value: got flags=%b upd=%b expected 0101/0", flags, flags_updated);
        end
        op_logic = 1'b0;
    endtask

    task automatic test_stack();
        flags_wr    = 1'b1;
        flags_wdata = 4'b1010;
        tick();
        idle();
        push = 1'b1;
        tick();
        idle();
        flags_wr    = 1'b1;
        flags_wdata = 4'b0001;
        tick();
        idle();
        push = 1'b1;
        tick();
        idle();
        checks++;
        if (stack_count !== CW'(2) || flags !== 4'b0001) begin
            failures++;
            $display("FAIL stack_two_pushes: got count=%0d flags=%b expected 2/0001", stack_count, flags);
        end
        pop = 1'b1;
        tick();
        idle();
        checks++;
        if (flags !== 4'b0001 || stack_count !== CW'(1) || flags_updated !== 1'b0) begin
            failures++;
            $display("FAIL stack_pop1: got flags=%b count=%0d upd=%b expected 0001/1/0",
                     flags, stack_count, flags_updated);
        end
        pop = 1'b1;
        tick();
        idle();
        checks++;
        if (flags !== 4'b1010 || stack_empty !== 1'b1 || flags_updated !== 1'b1 || stack_err !== 1'b0) begin
            failures++;
            $display("FAIL stack_pop2: got flags=%b empty=%b upd=%b err=%b expected 1010/1/1/0",
                     flags, stack_empty, flags_updated, stack_err);
        end
    endtask

    task automatic test_overflow_underflow();
        for (int i = 0; i < DEPTH; i++) begin
            push = 1'b1;
            tick();
            idle();
        end
        checks++;
        if (stack_full !== 1'b1 || stack_count !== CW'(DEPTH) || stack_err !== 1'b0) begin
            failures++;
            $display("FAIL fill: got full=%b count=%0d err=%b expected 1/%0d/0",
                     stack_full, stack_count, stack_err, DEPTH);
        end
        push = 1'b1;
        tick();
        idle();
        checks++;
        if (stack_full !== 1'b1 || stack_count !== CW'(DEPTH) || stack_err !== 1'b1) begin
            failures++;
            $display("FAIL overflow: got full=%b count=%0d err=%b expected 1/%0d/1",
                     stack_full, stack_count, stack_err, DEPTH);
        end
        err_clr = 1'b1;
        tick();
        idle();
        checks++;
        if (stack_err !== 1'b0) begin
            failures++;
            $display("FAIL err_clr: got %b expected 0", stack_err);
        end
        for (int i = 0; i < DEPTH; i++) begin
            pop = 1'b1;
            tick();
            idle();
        end
        checks++;
        if (stack_empty !== 1'b1 || flags !== 4'b1010 || stack_err !== 1'b0) begin
            failures++;
            $display("FAIL drain: got empty=%b flags=%b err=%b expected 1/1010/0",
                     stack_empty, flags, stack_err);
        end
        pop = 1'b1;
        tick();
        idle();
        checks++;
        if (stack_err !== 1'b1 || flags !== 4'b1010 || stack_count !== CW'(0)) begin
            failures++;
            $display("FAIL underflow: got err=%b flags=%b count=%0d expected 1/1010/0",
                     stack_err, flags, stack_count);
        end
        err_clr = 1'b1;
        tick();
        idle();
        // Error event and err_clr together: error wins
        pop     = 1'b1;
        err_clr = 1'b1;
        tick();
        idle();
        checks++;
        if (stack_err !== 1'b1) begin
            failures++;
            $display("FAIL err_wins_over_clr: got %b expected 1", stack_err);
        end
        err_clr = 1'b1;
        tick();
        idle();
        // Rejected pop lets the direct write through
        pop         = 1'b1;
        flags_wr    = 1'b1;
        flags_wdata = 4'b1100;
        tick();
        idle();
        checks++;
        if (flags !== 4'b1100 || stack_err !== 1'b1 || stack_count !== CW'(0)) begin
            failures++;
            $display("FAIL underflow_write: got flags=%b err=%b count=%0d expected 1100/1/0",
                     flags, stack_err, stack_count);
        end
        err_clr = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_priority();
        flags_wr    = 1'b1;
        flags_wdata = 4'b0110;
        tick();
        idle();
        push = 1'b1;
        tick();
        idle();
        flags_wr    = 1'b1;
        flags_wdata = 4'b0000;
        tick();
        idle();
        // ALU inputs would give 0101 if set_flags were honoured
        alu_result   = 32'd1;
        alu_carry    = 1'b1;
        alu_overflow = 1'b1;
        op_logic     = 1'b0;
        pop          = 1'b1;
        flags_wr     = 1'b1;
        flags_wdata  = 4'b1111;
        set_flags    = 1'b1;
        tick();
        idle();
        checks++;
        if (flags !== 4'b0110 || stack_count !== CW'(0) || stack_err !== 1'b0) begin
            failures++;
            $display("FAIL prio_pop: got flags=%b count=%0d err=%b expected 0110/0/0",
                     flags, stack_count, stack_err);
        end
        flags_wr    = 1'b1;
        flags_wdata = 4'b1111;
        set_flags   = 1'b1;
        tick();
        idle();
        checks++;
        if (flags !== 4'b1111) begin
            failures++;
            $display("FAIL prio_write: got %b expected 1111", flags);
        end
        set_flags = 1'b1;
        tick();
        idle();
        checks++;
        if (flags !== 4'b0101) begin
            failures++;
            $display("FAIL prio_alu: got %b expected 0101", flags);
        end
        // Push with a write: old value saved, new value loaded
        push        = 1'b1;
        flags_wr    = 1'b1;
        flags_wdata = 4'b1001;
        tick();
        idle();
        checks++;
        if (flags !== 4'b1001 || stack_count !== CW'(1)) begin
            failures++;
            $display("FAIL push_with_write: got flags=%b count=%0d expected 1001/1", flags, stack_count);
        end
        pop = 1'b1;
        tick();
        idle();
        checks++;
        if (flags !== 4'b0101 || stack_count !== CW'(0)) begin
            failures++;
            $display("FAIL push_with_write_pop: got flags=%b count=%0d expected 0101/0", flags, stack_count);
        end
    endtask

    task automatic test_push_pop_conflict();
        push = 1'b1;
        tick();
        idle();
        push        = 1'b1;
        pop         = 1'b1;
        flags_wr    = 1'b1;
        flags_wdata = 4'b0011;
        tick();
        idle();
        checks++;
        if (stack_err !== 1'b1 || stack_count !== CW'(1) || flags !== 4'b0011) begin
            failures++;
            $display("FAIL conflict: got err=%b count=%0d flags=%b expected 1/1/0011",
                     stack_err, stack_count, flags);
        end
        err_clr = 1'b1;
        tick();
        idle();
        pop = 1'b1;
        tick();
        idle();
        checks++;
        if (flags !== 4'b0101 || stack_count !== CW'(0) || stack_err !== 1'b0) begin
            failures++;
            $display("FAIL conflict_stack_intact: got flags=%b count=%0d err=%b expected 0101/0/0",
                     flags, stack_count, stack_err);
        end
    endtask

    task automatic test_async_reset();
        flags_wr    = 1'b1;
        flags_wdata = 4'b1011;
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            push = 1'b1;
            tick();
            idle();
        end
        push = 1'b1;
        pop  = 1'b1;
        tick();
        idle();
        checks++;
        if (stack_count !== CW'(3) || flags !== 4'b1011 || stack_err !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset: got count=%0d flags=%b err=%b expected 3/1011/1",
                     stack_count, flags, stack_err);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (flags !== 4'b0000 || stack_count !== CW'(0) || stack_err !== 1'b0 || stack_empty !== 1'b1) begin
            failures++;
            $display("FAIL async_reset: got flags=%b count=%0d err=%b empty=%b expected 0000/0/0/1",
                     flags, stack_count, stack_err, stack_empty);
        end
        tick();
        rst_n = 1'b1;
        tick();
        pop = 1'b1;
        tick();
        idle();
        checks++;
        if (stack_err !== 1'b1 || flags !== 4'b0000 || stack_count !== CW'(0)) begin
            failures++;
            $display("FAIL post_reset_pop: got err=%b flags=%b count=%0d expected 1/0000/0",
                     stack_err, flags, stack_count);
        end
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_alu_flags();
        test_stack();
        test_overflow_underflow();
        test_priority();
        test_push_pop_conflict();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
